// File: rtl/sim_status_port.sv
// Simulation-status responder on the SOPC data bus. Software reports a
// pass/fail verdict, a signature word and console characters; a cycle counter
// and a programmable watchdog force a timeout verdict if nothing is reported.
module sim_status_port #(
    parameter logic [31:0] BASE_ADDR       = 32'h1000_0000,
    parameter logic [31:0] DEFAULT_TIMEOUT = 32'd50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        sim_done,
    output logic        sim_pass,
    output logic        sim_timeout,
    output logic [31:0] signature,
    output logic        putc_valid,
    output logic [7:0]  putc_data,
    output logic [31:0] cycles
);

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_PASSED    = 2'd1;
    localparam logic [1:0] ST_FAILED    = 2'd2;
    localparam logic [1:0] ST_TIMED_OUT = 2'd3;

    localparam logic [7:0] OFF_STATUS  = 8'h00;
    localparam logic [7:0] OFF_SIG     = 8'h04;
    localparam logic [7:0] OFF_CYCLES  = 8'h08;
    localparam logic [7:0] OFF_TIMEOUT = 8'h0C;
    localparam logic [7:0] OFF_CONSOLE = 8'h10;

    logic [1:0]  state_q, state_d;
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] timeout_q, timeout_d;
    logic [31:0] sig_q, sig_d;
    logic        done_q, pass_q, tmo_q;
    logic        putc_valid_q, putc_valid_d;
    logic [7:0]  putc_data_q, putc_data_d;

    logic       hit;
    logic [7:0] offset;
    logic       wr;
    logic       running;

    assign hit     = ce & (addr[31:8] == BASE_ADDR[31:8]);
    assign offset  = addr[7:0];
    assign wr      = hit & we;
    assign running = (state_q == ST_RUN);

    // Verdict FSM: a CPU done-write takes priority over watchdog expiry.
    always_comb begin
        state_d = state_q;
        if (running) begin
            if (wr && offset == OFF_STATUS && data_i[0]) begin
                state_d = data_i[1] ? ST_PASSED : ST_FAILED;
            end else if (timeout_q != 32'd0 && cycles_q == timeout_q) begin
                state_d = ST_TIMED_OUT;
            end
        end
    end

    // Cycle counter runs only while no verdict is latched and saturates.
    always_comb begin
        cycles_d = cycles_q;
        if (running && cycles_q != 32'hFFFF_FFFF) begin
            cycles_d = cycles_q + 32'd1;
        end
    end

    // Register writes: signature per byte lane, timeout only as a full word.
    always_comb begin
        sig_d     = sig_q;
        timeout_d = timeout_q;
        if (wr && offset == OFF_SIG) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) begin
                    sig_d[8*b +: 8] = data_i[8*b +: 8];
                end
            end
        end
        if (wr && offset == OFF_TIMEOUT && sel == 4'b1111) begin
            timeout_d = data_i;
        end
    end

    // Console strobe for one cycle per accepted write; data holds afterwards.
    always_comb begin
        putc_valid_d = 1'b0;
        putc_data_d  = putc_data_q;
        if (wr && offset == OFF_CONSOLE && sel[0] && running) begin
            putc_valid_d = 1'b1;
            putc_data_d  = data_i[7:0];
        end
    end

    // State and flag registers; flags decode the next state so they move with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            cycles_q     <= 32'd0;
            timeout_q    <= DEFAULT_TIMEOUT;
            sig_q        <= 32'd0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            tmo_q        <= 1'b0;
            putc_valid_q <= 1'b0;
            putc_data_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            cycles_q     <= cycles_d;
            timeout_q    <= timeout_d;
            sig_q        <= sig_d;
            done_q       <= (state_d != ST_RUN);
            pass_q       <= (state_d == ST_PASSED);
            tmo_q        <= (state_d == ST_TIMED_OUT);
            putc_valid_q <= putc_valid_d;
            putc_data_q  <= putc_data_d;
        end
    end

    // Zero-latency read mux; anything other than a hit read returns 0.
    always_comb begin
        data_o = 32'd0;
        if (hit && !we) begin
            case (offset)
                OFF_STATUS:  data_o = {29'd0, tmo_q, pass_q, done_q};
                OFF_SIG:     data_o = sig_q;
                OFF_CYCLES:  data_o = cycles_q;
                OFF_TIMEOUT: data_o = timeout_q;
                default:     data_o = 32'd0;
            endcase
        end
    end

    assign sim_done    = done_q;
    assign sim_pass    = pass_q;
    assign sim_timeout = tmo_q;
    assign signature   = sig_q;
    assign putc_valid  = putc_valid_q;
    assign putc_data   = putc_data_q;
    assign cycles      = cycles_q;

endmodule

// File: tb/tb_sim_status_port.sv
// Bench for sim_status_port: directed scenarios followed by randomized bus
// traffic, all compared against a verdict-level reference model.
module tb_sim_status_port;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] DEF_TMO = 32'd50;

    localparam int V_RUN  = 0;
    localparam int V_PASS = 1;
    localparam int V_FAIL = 2;
    localparam int V_TMO  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        sim_done, sim_pass, sim_timeout;
    logic [31:0] signature;
    logic        putc_valid;
    logic [7:0]  putc_data;
    logic [31:0] cycles;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          m_verdict;
    logic [31:0] m_cyc;
    logic [31:0] m_tmo;
    logic [31:0] m_sig;
    logic        m_pv;
    logic [7:0]  m_pd;

    sim_status_port #(
        .BASE_ADDR(BASE),
        .DEFAULT_TIMEOUT(DEF_TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ce(ce),
        .we(we),
        .addr(addr),
        .sel(sel),
        .data_i(data_i),
        .data_o(data_o),
        .sim_done(sim_done),
        .sim_pass(sim_pass),
        .sim_timeout(sim_timeout),
        .signature(signature),
        .putc_valid(putc_valid),
        .putc_data(putc_data),
        .cycles(cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic c, input logic w,
                                               input logic [31:0] a);
        if (!c || w || a[31:8] != BASE[31:8]) return 32'd0;
        case (a[7:0])
            8'h00:   return {29'd0, m_verdict == V_TMO, m_verdict == V_PASS,
                             m_verdict != V_RUN};
            8'h04:   return m_sig;
            8'h08:   return m_cyc;
            8'h0C:   return m_tmo;
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one clock given the bus request seen before the edge.
    task automatic model_step(input logic c, input logic w, input logic [31:0] a,
                              input logic [3:0] s, input logic [31:0] d);
        bit hitw;
        bit run;
        hitw = c && w && (a[31:8] == BASE[31:8]);
        run  = (m_verdict == V_RUN);
        m_pv = 1'b0;
        if (hitw && a[7:0] == 8'h10 && s[0] && run) begin
            m_pv = 1'b1;
            m_pd = d[7:0];
        end
        if (hitw && a[7:0] == 8'h04) begin
            for (int b = 0; b < 4; b++) if (s[b]) m_sig[8*b +: 8] = d[8*b +: 8];
        end
        if (run) begin
            if (hitw && a[7:0] == 8'h00 && d[0]) m_verdict = d[1] ? V_PASS : V_FAIL;
            else if (m_tmo != 0 && m_cyc == m_tmo) m_verdict = V_TMO;
            if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
        end
        if (hitw && a[7:0] == 8'h0C && s == 4'hF) m_tmo = d;
    endtask

    task automatic check_outputs();
        check("done", {31'd0, sim_done}, {31'd0, m_verdict != V_RUN});
        check("pass", {31'd0, sim_pass}, {31'd0, m_verdict == V_PASS});
        check("timeout", {31'd0, sim_timeout}, {31'd0, m_verdict == V_TMO});
        check("cycles", cycles, m_cyc);
        check("signature", signature, m_sig);
        check("putc_valid", {31'd0, putc_valid}, {31'd0, m_pv});
        check("putc_data", {24'd0, putc_data}, {24'd0, m_pd});
    endtask

    // One bus cycle: drive, check combinational read, clock, check state.
    task automatic bus(input logic c, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
        ce = c; we = w; addr = a; sel = s; data_i = d;
        #1;
        check("data_o", data_o, model_read(c, w, a));
        @(posedge clk);
        model_step(c, w, a, s, d);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic do_reset();
        ce = 1'b0; we = 1'b0; addr = 32'd0; sel = 4'd0; data_i = 32'd0;
        reset = 1'b0;
        #1;
        check("rst_done", {31'd0, sim_done}, 32'd0);
        check("rst_pass", {31'd0, sim_pass}, 32'd0);
        check("rst_timeout", {31'd0, sim_timeout}, 32'd0);
        check("rst_putc_valid", {31'd0, putc_valid}, 32'd0);
        check("rst_putc_data", {24'd0, putc_data}, 32'd0);
        check("rst_signature", signature, 32'd0);
        check("rst_cycles", cycles, 32'd0);
        m_verdict = V_RUN; m_cyc = 0; m_tmo = DEF_TMO; m_sig = 0; m_pv = 0; m_pd = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        int r;
        reset = 1'b0; ce = 0; we = 0; addr = 0; sel = 0; data_i = 0;
        #12;
        do_reset();

        // Idle count and reset-value reads
        bus(1'b1, 1'b0, BASE + 32'h0C, 4'hF, 32'd0);
        idle(9);
        check("idle_cycles", cycles, 32'd10);
        bus(1'b1, 1'b0, BASE + 32'h08, 4'hF, 32'd0);
        idle(9);
        bus(1'b1, 1'b1, BASE + 32'h00, 4'hF, 32'h3);
        check("pass_cycles", cycles, 32'd21);
        check("pass_flag", {31'd0, sim_pass}, 32'd1);
        bus(1'b1, 1'b1, BASE + 32'h00, 4'hF, 32'h1);
        idle(3);
        check("pass_sticky", {31'd0, sim_pass}, 32'd1);
        check("pass_frozen", cycles, 32'd21);

        // Default watchdog
        do_reset();
        idle(60);
        check("wd_timeout", {31'd0, sim_timeout}, 32'd1);
        check("wd_cycles", cycles, 32'd51);
        bus(1'b1, 1'b0, BASE + 32'h00, 4'hF, 32'd0);
        bus(1'b1, 1'b1, BASE + 32'h00, 4'hF, 32'h3);
        check("wd_no_pass", {31'd0, sim_pass}, 32'd0);

        // CPU fail verdict on the same edge as watchdog expiry
        do_reset();
        bus(1'b1, 1'b1, BASE + 32'h0C, 4'hF, 32'd5);
        idle(4);
        check("tie_pre_cycles", cycles, 32'd5);
        bus(1'b1, 1'b1, BASE + 32'h00, 4'hF, 32'h1);
        check("tie_done", {31'd0, sim_done}, 32'd1);
        check("tie_no_timeout", {31'd0, sim_timeout}, 32'd0);

        // Console strobes and post-done suppression
        do_reset();
        bus(1'b1, 1'b1, BASE + 32'h10, 4'h1, 32'h48);
        check("putc_h", {24'd0, putc_data}, 32'h48);
        bus(1'b1, 1'b1, BASE + 32'h10, 4'h1, 32'h69);
        check("putc_i", {24'd0, putc_data}, 32'h69);
        check("putc_i_valid", {31'd0, putc_valid}, 32'd1);
        bus(1'b1, 1'b1, BASE + 32'h00, 4'hF, 32'h3);
        bus(1'b1, 1'b1, BASE + 32'h10, 4'h1, 32'h21);
        check("putc_after_done", {31'd0, putc_valid}, 32'd0);

        // Signature byte lanes, then async reset mid-run
        do_reset();
        bus(1'b1, 1'b1, BASE + 32'h04, 4'b0011, 32'hDEAD_BEEF);
        check("sig_lanes", signature, 32'h0000_BEEF);
        idle(3);

        // Randomized episodes
        for (int ep = 0; ep < 10; ep++) begin
            do_reset();
            for (int i = 0; i < 120; i++) begin
                r = $urandom_range(0, 99);
                a = BASE + 32'($urandom_range(0, 5) * 4);
                if (r < 30) begin
                    idle(1);
                end else if (r < 50) begin
                    bus(1'b1, 1'b0, a, 4'($urandom), $urandom);
                end else if (r < 62) begin
                    bus(1'b1, 1'b1, BASE + 32'h10, 4'($urandom), $urandom);
                end else if (r < 72) begin
                    bus(1'b1, 1'b1, BASE + 32'h04, 4'($urandom), $urandom);
                end else if (r < 80) begin
                    bus(1'b1, 1'b1, BASE + 32'h0C, ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom),
                        32'($urandom_range(0, 90)));
                end else if (r < 83) begin
                    bus(1'b1, 1'b1, BASE + 32'h00, 4'hF, 32'($urandom_range(0, 3)));
                end else if (r < 90) begin
                    bus(1'b1, 1'b1, BASE + 32'h08, 4'hF, $urandom);
                end else begin
                    // Off-base traffic, or a hit address with ce low
                    bus(r[0], 1'($urandom), (r[0] ? BASE + 32'h100 : BASE) + 32'($urandom_range(0, 4) * 4),
                        4'hF, $urandom);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
